// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the FSM state encoding and the MEM/WB bundle layout.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DWORD_BYTES = 8;

    typedef struct packed {
        logic [63:0] read_data;
        logic [63:0] alu_result;
        logic [4:0]  rd;
        logic        MemtoReg;
        logic        Regwrite;
        logic        overflow;
        logic        misaligned;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and stall of the MEM stage.
// master drives EX/MEM; slave is the MEM stage itself.
interface mem_stage_if;

    logic [63:0] ex_mem_alu_result;
    logic [63:0] ex_mem_write_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_Memwrite;
    logic        ex_mem_Memread;
    logic        ex_mem_MemtoReg;
    logic        ex_mem_Regwrite;
    logic        ex_mem_overflow;

    logic        mem_stall;
    logic [63:0] mem_wb_read_data;
    logic [63:0] mem_wb_alu_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_MemtoReg;
    logic        mem_wb_Regwrite;
    logic        mem_wb_overflow;
    logic        mem_wb_misaligned;

    modport master (
        output ex_mem_alu_result, ex_mem_write_data, ex_mem_rd,
        output ex_mem_Memwrite, ex_mem_Memread,
        output ex_mem_MemtoReg, ex_mem_Regwrite, ex_mem_overflow,
        input  mem_stall,
        input  mem_wb_read_data, mem_wb_alu_result, mem_wb_rd,
        input  mem_wb_MemtoReg, mem_wb_Regwrite,
        input  mem_wb_overflow, mem_wb_misaligned
    );

    modport slave (
        input  ex_mem_alu_result, ex_mem_write_data, ex_mem_rd,
        input  ex_mem_Memwrite, ex_mem_Memread,
        input  ex_mem_MemtoReg, ex_mem_Regwrite, ex_mem_overflow,
        output mem_stall,
        output mem_wb_read_data, mem_wb_alu_result, mem_wb_rd,
        output mem_wb_MemtoReg, mem_wb_Regwrite,
        output mem_wb_overflow, mem_wb_misaligned
    );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Doubleword data memory: asynchronous read, synchronous write.
// Contents are never reset.
module data_memory #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 write_en,
    input  logic [ADDR_BITS-1:0] index,
    input  logic [63:0]          write_data,
    output logic [63:0]          read_data
);

    logic [63:0] mem [DEPTH];

    // combinational read of the addressed doubleword
    assign read_data = mem[index];

    // commit a store on the closing edge of its completion cycle
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[index] <= write_data;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: doubleword loads/stores with multi-cycle
// access latency, upstream stall and the MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int OFF_BITS  = $clog2(DWORD_BYTES);
    localparam int CNT_BITS  =
        (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST =
        CNT_BITS'(MEM_LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_BITS-1:0]   cnt;
    logic [CNT_BITS-1:0]   cnt_nxt;
    logic                  memop;
    logic                  misaligned;
    logic                  aligned;
    logic                  complete;
    logic                  stall;
    logic                  write_en;
    logic [ADDR_BITS-1:0]  index;
    logic [63:0]           read_data;
    mem_wb_t               wb;
    mem_wb_t               wb_nxt;

    assign index =
        bus.ex_mem_alu_result[ADDR_BITS+OFF_BITS-1:OFF_BITS];

    // classify the access and decide stall / completion
    always_comb begin
        memop      = bus.ex_mem_Memread | bus.ex_mem_Memwrite;
        misaligned = memop &
            (bus.ex_mem_alu_result[OFF_BITS-1:0] != '0);
        aligned    = memop & ~misaligned;
        if (MEM_LATENCY == 1) begin
            complete = aligned;
        end else begin
            complete = (state == WAIT) && (cnt == CNT_LAST);
        end
        // reset aborts any access: no stall, no commit
        stall    = ~rst & aligned & ~complete;
        write_en = ~rst & complete & bus.ex_mem_Memwrite;
    end

    // next FSM state and latency counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (aligned && (MEM_LATENCY > 1)) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_BITS'(1);
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_BITS'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // next MEM/WB contents: bubble, fault entry or result
    always_comb begin
        wb_nxt = MEM_WB_BUBBLE;
        if (stall) begin
            wb_nxt = MEM_WB_BUBBLE;
        end else if (misaligned) begin
            wb_nxt.alu_result = bus.ex_mem_alu_result;
            wb_nxt.rd         = bus.ex_mem_rd;
            wb_nxt.overflow   = bus.ex_mem_overflow;
            wb_nxt.misaligned = 1'b1;
        end else begin
            wb_nxt.alu_result = bus.ex_mem_alu_result;
            wb_nxt.rd         = bus.ex_mem_rd;
            wb_nxt.MemtoReg   = bus.ex_mem_MemtoReg;
            wb_nxt.Regwrite   = bus.ex_mem_Regwrite;
            wb_nxt.overflow   = bus.ex_mem_overflow;
            // a store wins over a simultaneous load
            if (complete && bus.ex_mem_Memread &&
                !bus.ex_mem_Memwrite) begin
                wb_nxt.read_data = read_data;
            end
        end
    end

    // FSM, counter and MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wb    <= MEM_WB_BUBBLE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wb    <= wb_nxt;
        end
    end

    data_memory #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_dmem (
        .clk        (clk),
        .write_en   (write_en),
        .index      (index),
        .write_data (bus.ex_mem_write_data),
        .read_data  (read_data)
    );

    assign bus.mem_stall         = stall;
    assign bus.mem_wb_read_data  = wb.read_data;
    assign bus.mem_wb_alu_result = wb.alu_result;
    assign bus.mem_wb_rd         = wb.rd;
    assign bus.mem_wb_MemtoReg   = wb.MemtoReg;
    assign bus.mem_wb_Regwrite   = wb.Regwrite;
    assign bus.mem_wb_overflow   = wb.overflow;
    assign bus.mem_wb_misaligned = wb.misaligned;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 64-bit pipelined RISC-V core; sits directly downstream of ex_stage.
- Consumes ex_stage's EX/MEM register outputs and performs doubleword loads and stores into an internal data memory with configurable access latency.
- Asserts a stall to freeze upstream stages while an access is in flight.
- Drives the MEM/WB pipeline register consumed by writeback.

Parameters:
- DEPTH, 1024, number of 64-bit doublewords in the data memory (power of two); ADDR_BITS = log2(DEPTH) is a derived localparam.
- MEM_LATENCY, 2, cycles per memory access (>=1); 1 means single-cycle with no stall.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ex_mem_alu_result  in  64  ALU result; byte address for loads/stores
- ex_mem_write_data  in  64  store data (forwarded rs2)
- ex_mem_rd  in  5  destination register
- ex_mem_Memwrite  in  1  store request
- ex_mem_Memread  in  1  load request
- ex_mem_MemtoReg  in  1  writeback selects load data
- ex_mem_Regwrite  in  1  writeback enable
- ex_mem_overflow  in  1  ALU overflow flag
- mem_stall  out  1  combinational; high while upstream must hold EX/MEM
- mem_wb_read_data  out  64  load data
- mem_wb_alu_result  out  64  passthrough ALU result
- mem_wb_rd  out  5  destination register
- mem_wb_MemtoReg  out  1  passthrough
- mem_wb_Regwrite  out  1  writeback enable (qualified)
- mem_wb_overflow  out  1  passthrough
- mem_wb_misaligned  out  1  misaligned access flag

Behaviour:
- Reset (synchronous): all mem_wb_* outputs 0, FSM state IDLE, cnt = 0. Memory contents are not cleared.
- Reset during WAIT aborts the access: the pending store is never committed and no MEM/WB entry is produced.
- memop = Memread | Memwrite. Index = ex_mem_alu_result[ADDR_BITS+2:3]; upper address bits are ignored, so addresses wrap modulo DEPTH*8.
- Misaligned access:
  - Condition: memop with ex_mem_alu_result[2:0] != 0.
  - No memory access and no stall.
  - Next edge loads MEM/WB with mem_wb_misaligned = 1, Regwrite = 0, MemtoReg = 0, read_data = 0, and rd/alu_result/overflow passed through.
- Non-memop instruction: MEM/WB captures all passthrough fields on the next edge. read_data = 0, misaligned = 0, no stall.
- FSM states IDLE and WAIT, with cnt[ceil(log2(MEM_LATENCY))] counter:
  - IDLE, aligned memop, MEM_LATENCY==1: the access completes this cycle; no stall.
  - IDLE, aligned memop, MEM_LATENCY>1: mem_stall = 1; next state WAIT with cnt = 1.
  - WAIT, cnt < MEM_LATENCY-1: mem_stall = 1; cnt increments.
  - WAIT, cnt == MEM_LATENCY-1: completion cycle; mem_stall = 0; next state IDLE with cnt = 0.
- Completion cycle:
  - Store: memory word written at the closing edge, exactly once.
  - Load: read data captured into mem_wb_read_data.
  - All passthrough fields captured into MEM/WB.
- Every stalled cycle loads a bubble into MEM/WB: Regwrite = 0, MemtoReg = 0, rd = 0, misaligned = 0, read_data = 0, alu_result = 0, overflow = 0.
- Upstream contract: EX/MEM inputs are held constant while mem_stall = 1. Behaviour with changing inputs is undefined and is not checked.
- Memread and Memwrite both high: the write has priority; read_data = 0.
- Load latency: data visible on mem_wb_read_data MEM_LATENCY cycles after the access is first presented.
- Back-to-back memops: the second memop enters IDLE in the cycle after the first one's completion cycle; the stall pattern repeats.

Decomposition:
- Shared package mem_pkg:
  - state enum: IDLE = 1'b0, WAIT = 1'b1
  - DWORD_BYTES = 8
  - bubble constant for the MEM/WB bundle
- Sub-module data_memory:
  - DEPTH x 64 array, asynchronous read, synchronous write enable
  - instantiated once; FSM, counter and MEM/WB register stay in mem_stage

Test Plan:
- Reset: assert rst for 2 cycles after driving random inputs -> all mem_wb_* = 0, mem_stall = 0.
- Store/load, MEM_LATENCY=2:
  - store 64'hDEADBEEF_CAFEF00D to address 0x40 -> mem_stall high exactly 1 cycle, bubble in MEM/WB, then store completes.
  - subsequent load from 0x40 with rd = 5 -> mem_wb_read_data = 64'hDEADBEEF_CAFEF00D, mem_wb_rd = 5, Regwrite = 1, two cycles after presentation.
- ALU passthrough: Regwrite = 1, rd = 1, alu_result = 15, overflow = 1 -> next edge mem_wb_alu_result = 15, mem_wb_overflow = 1, no stall.
- Misaligned: load from 0x43 -> mem_wb_misaligned = 1, Regwrite = 0, no stall, memory unchanged.
- Wrap and priority:
  - store to address DEPTH*8 + 0x8 -> load from 0x8 returns the stored value.
  - Memread and Memwrite both high with data 64'h1 -> memory updated, read_data = 0.
- Reset mid-access: MEM_LATENCY=4, assert rst during WAIT cnt = 2 of a store to 0x10 -> the later load of 0x10 returns the prior value; FSM is in IDLE after reset.
